// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
// Contents: default widths, vector table base, interrupt id type and the
// sequencer state encoding. INT_FLAG_SAVE_EN controls whether PUSH_FLAGS is used.
package interrupt_sequencer_pkg;

  localparam int DEF_PC_W   = 32;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int NUM_INT    = 2;
  localparam int ID_W       = 1;

  localparam logic [15:0] DEF_VEC_BASE = 16'h0002;

  typedef logic [ID_W-1:0]    int_id_t;
  typedef logic [NUM_INT-1:0] int_vec_t;

  // Sequencer state encoding.
  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_DRAIN      = 4'd1;
  localparam logic [3:0] ST_PUSH_PC_HI = 4'd2;
  localparam logic [3:0] ST_PUSH_PC_LO = 4'd3;
  localparam logic [3:0] ST_PUSH_FLAGS = 4'd4;
  localparam logic [3:0] ST_RD_VEC_HI  = 4'd5;
  localparam logic [3:0] ST_RD_VEC_LO  = 4'd6;
  localparam logic [3:0] ST_LOAD_PC    = 4'd7;

  function automatic int_vec_t id_to_onehot(input int_id_t id);
    int_vec_t v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Data-memory port and stack-pointer decrement control shared by the sequencer.
// Latency: read data returns one cycle after memReadEn/memAddr.
// Backpressure: none; the memory accepts one access per cycle.
// Ports: master = sequencer (drives enables/address/write data/spDec),
//        slave  = memory side (returns memReadData).
interface interrupt_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              memReadEn;
  logic              memWriteEn;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;
  logic              spDec;

  modport master (
    output memReadEn, memWriteEn, memAddr, memWriteData, spDec,
    input  memReadData
  );

  modport slave (
    input  memReadEn, memWriteEn, memAddr, memWriteData, spDec,
    output memReadData
  );
endinterface

// File: rtl/interrupt_sequencer_int_pending_latch.sv
// Edge-detects the interrupt lines into sticky pending bits and picks a winner.
// Latency: an edge sampled in cycle N is visible in pending at cycle N+1.
// Backpressure: none; a bit stays pending until its own ack, so edges are never lost.
// Ports: clk/reset, irq (raw lines), ack (one-hot clear), pending, winner (INT0 first).
module int_pending_latch
  import interrupt_sequencer_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  int_vec_t irq,
  input  int_vec_t ack,
  output int_vec_t pending,
  output int_id_t  winner
);

  int_vec_t irq_q;
  int_vec_t rise;

  assign rise = irq & ~irq_q;

  // A new edge on the line being acknowledged wins over the clear, so a
  // request arriving in the ack cycle is serviced later rather than dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~ack) | rise;
    end
  end

  // Only meaningful when pending is non-zero.
  assign winner = pending[0] ? int_id_t'(0) : int_id_t'(1);

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: drain pipe, push return PC (and flags), fetch vector, load PC.
// Latency: entry decision to pcLoad = 7 cycles (6 when INT_FLAG_SAVE_EN undefined).
// Backpressure: entry waits for instrBoundary and for inService to clear (retiDone).
// Ports: clk/reset, interruptSignal[1:0], instrBoundary, pcIn, flagsIn, spIn, retiDone,
//        stallFetch, flushPipe, pcLoad/pcLoadValue, intAck, inService, mem (memory/SP port).
// Build option: INT_FLAG_SAVE_EN adds the PUSH_FLAGS state and flag save register.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int                PC_W     = DEF_PC_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(DEF_VEC_BASE)
) (
  input  logic              clk,
  input  logic              reset,
  input  int_vec_t          interruptSignal,
  input  logic              instrBoundary,
  input  logic [PC_W-1:0]   pcIn,
  input  logic [2:0]        flagsIn,
  input  logic [ADDR_W-1:0] spIn,
  input  logic              retiDone,
  output logic              stallFetch,
  output logic              flushPipe,
  output logic              pcLoad,
  output logic [PC_W-1:0]   pcLoadValue,
  output int_vec_t          intAck,
  output logic              inService,
  interrupt_sequencer_if.master mem
);

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  int_vec_t          pending;
  int_id_t           winner;
  int_id_t           id_q;
  logic [PC_W-1:0]   pc_save;
  logic [DATA_W-1:0] vec_hi;
  logic              entry;
  logic [ADDR_W-1:0] vec_addr;

`ifdef INT_FLAG_SAVE_EN
  logic [2:0] flags_save;
`else
  logic unused_flags;
  assign unused_flags = ^flagsIn;
`endif

  int_pending_latch u_pending (
    .clk     (clk),
    .reset   (reset),
    .irq     (interruptSignal),
    .ack     (intAck),
    .pending (pending),
    .winner  (winner)
  );

  assign entry = (state == ST_IDLE) && (|pending) && !inService && instrBoundary;

  // Hi word of vector n lives at VEC_BASE + 2n; wraps in ADDR_W bits.
  assign vec_addr = VEC_BASE + {{(ADDR_W-ID_W-1){1'b0}}, id_q, 1'b0};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (entry) state_nxt = ST_DRAIN;
      ST_DRAIN:      state_nxt = ST_PUSH_PC_HI;
      ST_PUSH_PC_HI: state_nxt = ST_PUSH_PC_LO;
`ifdef INT_FLAG_SAVE_EN
      ST_PUSH_PC_LO: state_nxt = ST_PUSH_FLAGS;
      ST_PUSH_FLAGS: state_nxt = ST_RD_VEC_HI;
`else
      ST_PUSH_PC_LO: state_nxt = ST_RD_VEC_HI;
`endif
      ST_RD_VEC_HI:  state_nxt = ST_RD_VEC_LO;
      ST_RD_VEC_LO:  state_nxt = ST_LOAD_PC;
      ST_LOAD_PC:    state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      id_q      <= '0;
      pc_save   <= '0;
      vec_hi    <= '0;
      inService <= 1'b0;
`ifdef INT_FLAG_SAVE_EN
      flags_save <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (entry) begin
        pc_save <= pcIn;
        id_q    <= winner;
`ifdef INT_FLAG_SAVE_EN
        flags_save <= flagsIn;
`endif
      end
      // Read data for the hi vector word arrives during RD_VEC_LO.
      if (state == ST_RD_VEC_LO) vec_hi <= mem.memReadData;
      // Setting on LOAD_PC exit takes precedence over an RTI in that cycle.
      if (state == ST_LOAD_PC)   inService <= 1'b1;
      else if (retiDone)         inService <= 1'b0;
    end
  end

  always_comb begin
    stallFetch       = (state != ST_IDLE);
    flushPipe        = 1'b0;
    intAck           = '0;
    pcLoad           = 1'b0;
    pcLoadValue      = '0;
    mem.memReadEn    = 1'b0;
    mem.memWriteEn   = 1'b0;
    mem.memAddr      = '0;
    mem.memWriteData = '0;
    mem.spDec        = 1'b0;
    case (state)
      ST_DRAIN: begin
        flushPipe = 1'b1;
        intAck    = id_to_onehot(id_q);
      end
      ST_PUSH_PC_HI: begin
        mem.memWriteEn   = 1'b1;
        mem.memAddr      = spIn;
        mem.spDec        = 1'b1;
        mem.memWriteData = pc_save[PC_W-1 -: DATA_W];
      end
      ST_PUSH_PC_LO: begin
        mem.memWriteEn   = 1'b1;
        mem.memAddr      = spIn;
        mem.spDec        = 1'b1;
        mem.memWriteData = pc_save[DATA_W-1:0];
      end
`ifdef INT_FLAG_SAVE_EN
      ST_PUSH_FLAGS: begin
        mem.memWriteEn   = 1'b1;
        mem.memAddr      = spIn;
        mem.spDec        = 1'b1;
        mem.memWriteData = DATA_W'(flags_save);
      end
`endif
      ST_RD_VEC_HI: begin
        mem.memReadEn = 1'b1;
        mem.memAddr   = vec_addr;
      end
      ST_RD_VEC_LO: begin
        mem.memReadEn = 1'b1;
        mem.memAddr   = vec_addr + ADDR_W'(1);
      end
      ST_LOAD_PC: begin
        pcLoad      = 1'b1;
        pcLoadValue = PC_W'({vec_hi, mem.memReadData});
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;
  import interrupt_sequencer_pkg::*;

`ifdef INT_FLAG_SAVE_EN
  localparam int SEQ_LEN = 7;
`else
  localparam int SEQ_LEN = 6;
`endif
  localparam logic [15:0] VB = 16'h0002;
  localparam int K_ACK = 0, K_WR = 1, K_LOAD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  interruptSignal;
  logic        instrBoundary;
  logic [31:0] pcIn;
  logic [2:0]  flagsIn;
  logic [15:0] spIn = 16'h07FF;
  logic        retiDone;
  logic        stallFetch, flushPipe, pcLoad, inService;
  logic [31:0] pcLoadValue;
  logic [1:0]  intAck;

  always #5 clk = ~clk;

  interrupt_sequencer_if mem_if ();

  interrupt_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .interruptSignal (interruptSignal),
    .instrBoundary   (instrBoundary),
    .pcIn            (pcIn),
    .flagsIn         (flagsIn),
    .spIn            (spIn),
    .retiDone        (retiDone),
    .stallFetch      (stallFetch),
    .flushPipe       (flushPipe),
    .pcLoad          (pcLoad),
    .pcLoadValue     (pcLoadValue),
    .intAck          (intAck),
    .inService       (inService),
    .mem             (mem_if)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t q[$];
  int checks = 0;
  int errors = 0;
  int ack_seen = 0;
  bit started = 0;

  function automatic logic [15:0] vt(input logic [15:0] a);
    case (a)
      16'h0002: return 16'h0000;
      16'h0003: return 16'h0040;
      16'h0004: return 16'h0001;
      16'h0005: return 16'h2345;
      default:  return 16'hDEAD;
    endcase
  endfunction

  // Memory / stack environment: capture requests at the edge, respond #1 later.
  logic        env_re, env_sd;
  logic [15:0] env_a;
  initial mem_if.memReadData = 16'h0;
  always @(posedge clk) begin
    env_re = mem_if.memReadEn;
    env_sd = mem_if.spDec;
    env_a  = mem_if.memAddr;
    #1;
    if (env_re) mem_if.memReadData = vt(env_a);
    if (env_sd) spIn = spIn - 16'd1;
  end

  // Reference model: cycle-stamped expectations derived from the entry rules.
  int          cyc = 0;
  int          seq_s = -1, seq_e = -2, ack_c = -1, m_id = 0;
  logic [1:0]  m_pend = 0, m_prev = 0, m_rise;
  logic        m_insvc = 0;
  logic [15:0] m_base;

  function automatic ev_t mk(input int c, input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.cyc = c; e.kind = k; e.a = a; e.b = b;
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_pend = 0; m_prev = 0; m_insvc = 0;
      seq_s = -1; seq_e = -2; ack_c = -1;
    end else begin
      m_rise = interruptSignal & ~m_prev;
      m_prev = interruptSignal;
      if (!(cyc >= seq_s && cyc <= seq_e) && m_pend != 0 && !m_insvc && instrBoundary) begin
        m_id   = m_pend[0] ? 0 : 1;
        m_base = VB + 16'(2 * m_id);
        q.push_back(mk(cyc + 1, K_ACK, 32'(3'b100 | (3'b001 << m_id)), 0));
        q.push_back(mk(cyc + 2, K_WR, 32'(spIn), 32'(pcIn[31:16])));
        q.push_back(mk(cyc + 3, K_WR, 32'(16'(spIn - 16'd1)), 32'(pcIn[15:0])));
`ifdef INT_FLAG_SAVE_EN
        q.push_back(mk(cyc + 4, K_WR, 32'(16'(spIn - 16'd2)), 32'(flagsIn)));
`endif
        q.push_back(mk(cyc + SEQ_LEN, K_LOAD, {vt(m_base), vt(m_base + 16'd1)}, 0));
        seq_s = cyc + 1;
        seq_e = cyc + SEQ_LEN;
        ack_c = cyc + 1;
      end
      if (cyc == ack_c) m_pend[m_id] = 1'b0;
      m_pend = m_pend | m_rise;
      if (cyc == seq_e) m_insvc = 1'b1;
      else if (retiDone) m_insvc = 1'b0;
    end
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d a=%h b=%h cycle=%0d", kind, a, b, cyc);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.a !== a || e.b !== b) begin
        errors++;
        $display("FAIL event got kind=%0d a=%h b=%h cyc=%0d want kind=%0d a=%h b=%h cyc=%0d",
                 kind, a, b, cyc, e.kind, e.a, e.b, e.cyc);
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event kind=%0d want_cycle=%0d now=%0d", q[0].kind, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      chk("stall", 32'(stallFetch), 32'(cyc >= seq_s && cyc <= seq_e));
      chk("in_service", 32'(inService), 32'(m_insvc));
      if (intAck != 0 || flushPipe) begin
        ack_seen++;
        observe(K_ACK, 32'({flushPipe, intAck}), 0);
      end
      if (mem_if.memWriteEn) observe(K_WR, 32'(mem_if.memAddr), 32'(mem_if.memWriteData));
      if (pcLoad) observe(K_LOAD, pcLoadValue, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({stallFetch, flushPipe, mem_if.memReadEn, mem_if.memWriteEn,
                            mem_if.spDec, pcLoad, intAck, inService}), 0);
    chk({tag, "_addr"}, 32'(mem_if.memAddr), 0);
    chk({tag, "_wdata"}, 32'(mem_if.memWriteData), 0);
    chk({tag, "_pcval"}, pcLoadValue, 0);
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 50; i++) begin
      step();
      if (intAck != 0) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_ack timeout got=none want=intAck");
  endtask

  task automatic reti();
    retiDone = 1'b1;
    step();
    retiDone = 1'b0;
  endtask

  int ack_before;

  initial begin
    reset = 1'b1; interruptSignal = 0; instrBoundary = 0;
    pcIn = 0; flagsIn = 0; retiDone = 0;
    step();
    started = 1;
    steps(2);
    outs_zero("reset");
    reset = 1'b0;
    step();

    // Single INT0 entry with known PC / SP / vector.
    pcIn = 32'h0001_0023; flagsIn = 3'b101; instrBoundary = 1'b1;
    interruptSignal = 2'b01;
    steps(3);
    interruptSignal = 2'b00;
    steps(12);
    reti();
    steps(2);

    // Simultaneous edges: INT0 first, INT1 after RTI.
    pcIn = 32'h1234_5678; flagsIn = 3'b010;
    interruptSignal = 2'b11;
    steps(12);
    interruptSignal = 2'b00;
    reti();
    steps(12);
    reti();
    steps(2);

    // Entry held off by instrBoundary.
    instrBoundary = 1'b0; pcIn = 32'hCAFE_0001;
    interruptSignal = 2'b01;
    steps(5);
    instrBoundary = 1'b1;
    steps(12);
    interruptSignal = 2'b00;
    reti();
    steps(2);

    // Level held high across RTI triggers only once.
    ack_before = ack_seen;
    interruptSignal = 2'b01;
    steps(12);
    reti();
    steps(8);
    interruptSignal = 2'b00;
    steps(2);
    chk("held_level_entries", 32'(ack_seen - ack_before), 1);

    // Reset during PUSH_PC_LO with an INT1 edge latched mid-sequence.
    interruptSignal = 2'b01;
    wait_ack();
    interruptSignal = 2'b10;
    step();
    interruptSignal = 2'b00;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    outs_zero("mid_reset");
    ack_before = ack_seen;
    steps(15);
    chk("pending_cleared", 32'(ack_seen - ack_before), 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) interruptSignal[0] = ~interruptSignal[0];
      if ($urandom_range(0, 5) == 0) interruptSignal[1] = ~interruptSignal[1];
      instrBoundary = ($urandom_range(0, 2) != 0);
      pcIn          = $urandom;
      flagsIn       = 3'($urandom);
      retiDone      = ($urandom_range(0, 9) == 0);
      reset         = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; retiDone = 1'b0; interruptSignal = 2'b00; instrBoundary = 1'b1;

    // Drain everything still pending.
    for (int i = 0; i < 4; i++) begin
      steps(11);
      reti();
    end
    steps(12);
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Multi-cycle sequencer that owns interrupt entry for the 16-bit processor core. It edge-detects the two external interrupt lines and waits for an instruction boundary. It then stalls and flushes the pipeline, pushes the return PC (and optionally flags) onto the data-memory stack, fetches the handler address from the vector table, and redirects the PC. It sits beside the main controller, muxing onto the data-memory port and SP-decrement control only while active.

## Interface
Parameters:
- PC_W, 32, program counter width (pushed as two 16-bit words)
- DATA_W, 16, memory word width
- ADDR_W, 16, data-memory address width
- VEC_BASE, 16'h0002, address of vector table; INTn vector at VEC_BASE+2n (hi word), +2n+1 (lo word)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- interruptSignal  in  2  external requests, bit0=INT0, bit1=INT1
- instrBoundary  in  1  pipeline may be redirected this cycle
- pcIn  in  PC_W  resume PC of the next unexecuted instruction
- flagsIn  in  3  {C,N,Z} current flags
- spIn  in  ADDR_W  current stack pointer
- memReadData  in  DATA_W  data-memory read data (1-cycle latency)
- retiDone  in  1  one-cycle pulse when RTI retires
- stallFetch  out  1  hold PC/fetch
- flushPipe  out  1  squash in-flight instructions (1 cycle)
- memReadEn, memWriteEn  out  1 each
- memAddr  out  ADDR_W
- memWriteData  out  DATA_W
- spDec  out  1  datapath decrements SP by 1 next edge
- pcLoad  out  1  one-cycle pulse, load pcLoadValue
- pcLoadValue  out  PC_W
- intAck  out  2  one-hot one-cycle acknowledge
- inService  out  1  handler running; further entry blocked

## Operation
- Rising edge of interruptSignal[n] (vs. previous-cycle sample) sets pending[n]; level held high does not re-trigger. Pending cleared only by its own intAck.
- Priority: INT0 over INT1; loser stays pending.
- States: IDLE → DRAIN → PUSH_PC_HI → PUSH_PC_LO → [PUSH_FLAGS] → RD_VEC_HI → RD_VEC_LO → LOAD_PC → IDLE.
- IDLE leaves only when pending≠0, inService=0, instrBoundary=1; on that edge captures pcIn, flagsIn, winning id.
- DRAIN: stallFetch=1, flushPipe=1, intAck[id]=1.
- PUSH_*: memWriteEn=1, memAddr=spIn, spDec=1; data = pcSave[31:16], pcSave[15:0], {13'b0,flagsSave}. Stack grows down.
- RD_VEC_HI: memReadEn=1, addr VEC_BASE+2·id. RD_VEC_LO: addr +1, register memReadData as vecHi.
- LOAD_PC: pcLoad=1, pcLoadValue={vecHi, memReadData}; inService set on exit.
- stallFetch=1 in every non-IDLE state; all other outputs 0 outside their states.
- retiDone clears inService; if a request is pending, entry may start the following cycle. retiDone while not inService is ignored.
- Edges arriving during a sequence or while inService are latched, not lost.

## Timing
- Reset: state IDLE, pending=0, inService=0, every output 0.
- Condition true in IDLE at cycle 0 → DRAIN cycle 1, pushes cycles 2–4, vector reads 5–6, pcLoad cycle 7, IDLE cycle 8 (without flag save: pcLoad cycle 6).
- Edge at cycle 0 sets pending visible cycle 1; earliest DRAIN cycle 2.
- Reset asserted mid-sequence: next cycle IDLE, no further writes/loads; pending edges discarded.
- Vector address arithmetic in ADDR_W bits, wraps modulo 2^ADDR_W.

## Configuration
- INT_FLAG_SAVE_EN defined: PUSH_FLAGS present, three pushes, SP decremented by 3 per entry.
- Undefined: PUSH_FLAGS state and flagsSave register removed, two pushes, flagsIn unused, latency one cycle shorter.

## Structure
- Shared package: state encoding enum, DATA_W/PC_W constants, VEC_BASE default, interrupt id width.
- Sub-module int_pending_latch: edge detection, pending bits, priority select, clear-on-ack; sequencer FSM in top.

## Test plan
- Reset then INT0 edge with instrBoundary=1, pcIn=32'h0001_0023, spIn=16'h07FF, mem[2..3]=16'h0000,16'h0040 → writes 0x0001@07FF, 0x0023@07FE, flags@07FD, pcLoad 32'h0000_0040 at cycle 7.
- INT0 and INT1 rising same cycle → INT0 serviced (vector at 2), INT1 stays pending, serviced the cycle after retiDone (vector at 4).
- instrBoundary=0 for 5 cycles after edge → stays IDLE, no stall; enters DRAIN the cycle after boundary rises.
- interruptSignal held high 20 cycles through retiDone → exactly one entry.
- reset pulsed in PUSH_PC_LO → all outputs 0 next cycle, no pcLoad, pending cleared.
- INT_FLAG_SAVE_EN undefined → only two memWriteEn cycles, pcLoad at cycle 6.
